// File: rtl/dmx_universe_rx.sv
// dmx_universe_rx: DMX512 receiver that writes a window of slots (from base_address) into a frame buffer,
// flagging frame completion and framing errors.
module dmx_universe_rx #(
    parameter int          CLK_HZ       = 48_000_000,
    parameter int          BAUD         = 250_000,
    parameter int          BREAK_US     = 88,
    parameter int          DMX_CHANNELS = 192,
    parameter int          ADDR_WIDTH   = 9,
    parameter logic [7:0]  START_CODE   = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dmx_in,
    input  logic [ADDR_WIDTH-1:0] base_address,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [7:0]            data,
    output logic                  write_strobe,
    output logic                  frame_done,
    output logic                  frame_error
);
    localparam int BIT_TICKS   = CLK_HZ / BAUD;
    localparam int BREAK_TICKS = CLK_HZ / 1_000_000 * BREAK_US;
    localparam int LOW_MAX     = BREAK_TICKS > BIT_TICKS * 10 ? BREAK_TICKS : BIT_TICKS * 10;
    localparam int LW          = $clog2(LOW_MAX + 1);
    localparam int TW          = $clog2(BIT_TICKS + 1);

    typedef enum logic [2:0] {IDLE, BREAK, MAB, START, DATA, STOP, WAIT} state_t;

    state_t                state, state_n;
    logic                  rx_meta, rx, sc_ok;
    logic [LW-1:0]         low_cnt;
    logic [TW-1:0]         tick;
    logic [2:0]            bit_cnt;
    logic [7:0]            shift;
    logic [9:0]            slot;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [10:0]           win_lo, win_hi;
    logic                  tick_half, tick_end, accept, stop_err, in_win;

    assign tick_half = tick == TW'(BIT_TICKS / 2);
    assign tick_end  = tick == TW'(BIT_TICKS - 1);
    assign accept    = state == STOP && tick_end && rx;
    assign stop_err  = state == STOP && tick_end && !rx;
    assign win_lo    = 11'(base_q);
    assign win_hi    = win_lo + 11'(DMX_CHANNELS);
    assign in_win    = {1'b0, slot} >= win_lo && {1'b0, slot} < win_hi;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (!rx) state_n = BREAK;
            BREAK:   if (rx) state_n = low_cnt >= LW'(BREAK_TICKS) ? MAB : IDLE;
            MAB:     if (!rx) state_n = START;
            START:   if (tick_half) state_n = rx ? IDLE : DATA;
            DATA:    if (tick_end && bit_cnt == 3'd7) state_n = STOP;
            STOP:    if (tick_end) state_n = !rx ? BREAK : (slot > 10'd512 ? IDLE : WAIT);
            WAIT:    if (!rx) state_n = START;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta      <= 1'b1;
            rx           <= 1'b1;
            state        <= IDLE;
            low_cnt      <= '0;
            tick         <= '0;
            bit_cnt      <= '0;
            shift        <= '0;
            slot         <= '0;
            base_q       <= '0;
            sc_ok        <= 1'b0;
            address      <= '0;
            data         <= '0;
            write_strobe <= 1'b0;
            frame_done   <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            rx_meta      <= dmx_in;
            rx           <= rx_meta;
            state        <= state_n;
            tick         <= (state_n != state || tick_end) ? '0 : tick + TW'(1);
            bit_cnt      <= state != DATA ? 3'd0 : (tick_end ? bit_cnt + 3'd1 : bit_cnt);
            write_strobe <= 1'b0;
            frame_done   <= write_strobe && address == ADDR_WIDTH'(DMX_CHANNELS - 1);
            frame_error  <= stop_err;
            // A failed stop bit is credited as partial low time so a break that began mid-slot still qualifies
            if (state == IDLE)
                low_cnt <= LW'(1);
            else if (stop_err)
                low_cnt <= LW'(BIT_TICKS * 10);
            else if (state == BREAK && low_cnt != {LW{1'b1}})
                low_cnt <= low_cnt + LW'(1);
            if (state == DATA && tick_end)
                shift <= {rx, shift[7:1]};
            if (state == MAB && !rx) begin
                base_q <= base_address == '0 ? ADDR_WIDTH'(1) : base_address;
                slot   <= '0;
            end
            if (accept) begin
                slot <= slot + 10'd1;
                if (slot == 10'd0)
                    sc_ok <= shift == START_CODE;
                else if (slot > 10'd512)
                    frame_error <= 1'b1;
                else if (sc_ok && in_win) begin
                    write_strobe <= 1'b1;
                    address      <= ADDR_WIDTH'({1'b0, slot} - win_lo);
                    data         <= shift;
                end
            end
        end
    end
endmodule
